// File: rtl/gon_collector.sv
// Gather-network collector: id scan-chain programming, tagged value collection, output FIFO.
// Optional perf counters (stall_cnt, idle_cnt) are built when GON_COLLECTOR_PERF_EN is defined.
module gon_collector #(
  parameter int ID_LEN     = 4,
  parameter int VALUE_LEN  = 32,
  parameter int CHAIN_LEN  = 12,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 prog_valid,
  input  logic [ID_LEN-1:0]    prog_id,
  output logic                 prog_ready,
  output logic                 prog_done,
  output logic                 set_id,
  output logic [ID_LEN-1:0]    id_out,
  input  logic                 start,
  input  logic [ID_LEN-1:0]    tag_first,
  input  logic [ID_LEN-1:0]    tag_last,
  input  logic [7:0]           beats_per_tag,
  output logic [ID_LEN-1:0]    tag,
  output logic                 net_ready,
  input  logic                 net_enable,
  input  logic [VALUE_LEN-1:0] net_value,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [VALUE_LEN-1:0] out_data,
  output logic [ID_LEN-1:0]    out_tag,
  output logic                 busy,
  output logic                 done
`ifdef GON_COLLECTOR_PERF_EN
  ,
  output logic [31:0]          stall_cnt,
  output logic [31:0]          idle_cnt
`endif
);

  localparam int AW  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int PCW = (CHAIN_LEN > 1) ? $clog2(CHAIN_LEN) : 1;
  localparam logic [AW:0]    FIFO_FULL = (AW+1)'(FIFO_DEPTH);
  localparam logic [PCW-1:0] PROG_LAST = PCW'(CHAIN_LEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_PROG, S_COLLECT, S_DRAIN} state_t;

  state_t                      state;
  logic [PCW-1:0]              prog_cnt;
  logic [ID_LEN-1:0]           cur_tag;
  logic [ID_LEN-1:0]           last_tag;
  logic [7:0]                  beat_cnt;
  logic [7:0]                  beat_last;
  logic [AW:0]                 count;
  logic [AW-1:0]               wr_ptr;
  logic [AW-1:0]               rd_ptr;
  logic [ID_LEN+VALUE_LEN-1:0] mem [FIFO_DEPTH];

  logic prog_acc;
  logic in_collect;
  logic capture;
  logic pop;

  assign prog_acc   = (state == S_PROG) && prog_valid;
  assign prog_ready = (state == S_PROG);
  assign set_id     = prog_acc;
  assign id_out     = prog_acc ? prog_id : '0;

  // Full FIFO blocks capture even when the head pops in the same cycle.
  assign in_collect = (state == S_COLLECT);
  assign net_ready  = in_collect && (count < FIFO_FULL);
  assign capture    = net_ready && net_enable;
  assign tag        = in_collect ? cur_tag : '0;

  assign out_valid           = (count != '0);
  assign pop                 = out_valid && out_ready;
  assign {out_tag, out_data} = out_valid ? mem[rd_ptr] : '0;
  assign busy                = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= S_IDLE;
      prog_cnt  <= '0;
      cur_tag   <= '0;
      last_tag  <= '0;
      beat_cnt  <= '0;
      beat_last <= '0;
      prog_done <= 1'b0;
      done      <= 1'b0;
    end else begin
      prog_done <= 1'b0;
      done      <= 1'b0;
      case (state)
        S_IDLE: begin
          if (prog_valid) begin
            state    <= S_PROG;
            prog_cnt <= '0;
          end else if (start) begin
            state     <= S_COLLECT;
            cur_tag   <= tag_first;
            last_tag  <= tag_last;
            beat_cnt  <= '0;
            // A beat count of zero behaves as one beat per tag.
            beat_last <= (beats_per_tag == 8'd0) ? 8'd0 : beats_per_tag - 8'd1;
          end
        end
        S_PROG: begin
          if (prog_acc) begin
            if (prog_cnt == PROG_LAST) begin
              prog_cnt  <= '0;
              prog_done <= 1'b1;
              state     <= S_IDLE;
            end else begin
              prog_cnt <= prog_cnt + 1'b1;
            end
          end
        end
        S_COLLECT: begin
          if (capture) begin
            if (beat_cnt == beat_last) begin
              beat_cnt <= '0;
              // Tag advances modulo 2^ID_LEN, so tag_last below tag_first wraps.
              if (cur_tag == last_tag) state <= S_DRAIN;
              else                     cur_tag <= cur_tag + 1'b1;
            end else begin
              beat_cnt <= beat_cnt + 8'd1;
            end
          end
        end
        S_DRAIN: begin
          if (count == '0) begin
            done    <= 1'b1;
            cur_tag <= '0;
            state   <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (capture) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      case ({capture, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; out_valid masks stale entries.
  always_ff @(posedge clk) begin
    if (capture) mem[wr_ptr] <= {cur_tag, net_value};
  end

`ifdef GON_COLLECTOR_PERF_EN
  logic perf_clr;
  assign perf_clr = (state == S_IDLE) && start && !prog_valid;

  always_ff @(posedge clk) begin
    if (!rst || perf_clr) begin
      stall_cnt <= '0;
      idle_cnt  <= '0;
    end else if (in_collect) begin
      if (!net_ready && (stall_cnt != '1))               stall_cnt <= stall_cnt + 32'd1;
      if (net_ready && !net_enable && (idle_cnt != '1))  idle_cnt  <= idle_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_gon_collector.sv
// Self-checking bench for gon_collector: table-driven randomized collection runs plus
// hand-written programming, reset and priority sequences.
module tb_gon_collector;

  logic        clk = 1'b0;
  logic        rst;
  logic        prog_valid;
  logic [3:0]  prog_id;
  logic        prog_ready;
  logic        prog_done;
  logic        set_id;
  logic [3:0]  id_out;
  logic        start;
  logic [3:0]  tag_first;
  logic [3:0]  tag_last;
  logic [7:0]  beats;
  logic [3:0]  tag;
  logic        net_ready;
  logic        net_enable;
  logic [31:0] net_value;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_tag;
  logic        busy;
  logic        done;
`ifdef GON_COLLECTOR_PERF_EN
  logic [31:0] stall_cnt;
  logic [31:0] idle_cnt;
`endif

  int checks   = 0;
  int failures = 0;

  gon_collector dut (
    .clk(clk), .rst(rst),
    .prog_valid(prog_valid), .prog_id(prog_id), .prog_ready(prog_ready),
    .prog_done(prog_done), .set_id(set_id), .id_out(id_out),
    .start(start), .tag_first(tag_first), .tag_last(tag_last),
    .beats_per_tag(beats), .tag(tag), .net_ready(net_ready),
    .net_enable(net_enable), .net_value(net_value),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .busy(busy), .done(done)
`ifdef GON_COLLECTOR_PERF_EN
    , .stall_cnt(stall_cnt), .idle_cnt(idle_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int tf;
    int tl;
    int bt;
    int en_pct;
    int rdy_pct;
    int hold;
    int exp_n;
  } vec_t;

  vec_t vecs[8];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
    end
  endtask

  task automatic check_zero(input string pfx);
    chk({pfx, "_prog_ready"}, 64'(prog_ready), 64'd0);
    chk({pfx, "_prog_done"},  64'(prog_done),  64'd0);
    chk({pfx, "_set_id"},     64'(set_id),     64'd0);
    chk({pfx, "_id_out"},     64'(id_out),     64'd0);
    chk({pfx, "_tag"},        64'(tag),        64'd0);
    chk({pfx, "_net_ready"},  64'(net_ready),  64'd0);
    chk({pfx, "_out_valid"},  64'(out_valid),  64'd0);
    chk({pfx, "_out_data"},   64'(out_data),   64'd0);
    chk({pfx, "_out_tag"},    64'(out_tag),    64'd0);
    chk({pfx, "_busy"},       64'(busy),       64'd0);
    chk({pfx, "_done"},       64'(done),       64'd0);
  endtask

  // Reference: the expected stream is every tag from tf to tl (mod 16), each repeated
  // max(bt,1) times; occupancy is captures minus pops, bounded by a 4-entry FIFO.
  task automatic run_collect(input int tf, input int tl, input int bt, input int en_pct,
                             input int rdy_pct, input int hold, input int exp_n);
    logic [3:0]  et[$];
    logic [31:0] ev[$];
    logic [3:0]  exp_tag;
    int nb, t, k, j, occ, cyc, n;
    bit done_exp, done_seen, collecting, cap, pp, done_nx;
    nb = (bt == 0) ? 1 : bt;
    t  = tf;
    forever begin
      for (int b = 0; b < nb; b++) begin
        et.push_back(4'(t));
        ev.push_back($urandom);
      end
      if (t == tl) break;
      t = (t + 1) % 16;
    end
    n = et.size();
    @(negedge clk);
    start = 1'b1; tag_first = 4'(tf); tag_last = 4'(tl); beats = 8'(bt);
    out_ready = 1'b0; net_enable = 1'b0; net_value = '0;
    #1;
    chk("start_busy", 64'(busy), 64'd0);
    k = 0; j = 0; occ = 0; cyc = 0; done_exp = 0; done_seen = 0;
    while (!done_seen && cyc < 3000) begin
      @(negedge clk);
      start     = 1'b0;
      tag_first = 4'($urandom);
      tag_last  = 4'($urandom);
      beats     = 8'($urandom);
      collecting = (k < n);
      exp_tag    = collecting ? et[k] : 4'd0;
      out_ready  = (cyc < hold) ? 1'b0 : ($urandom_range(99) < rdy_pct);
      net_enable = 1'b0;
      if (collecting && tag == exp_tag) net_enable = ($urandom_range(99) < en_pct);
      net_value  = (net_enable && collecting) ? ev[k] : 32'd0;
      #1;
      chk("tag",       64'(tag),       64'(exp_tag));
      chk("net_ready", 64'(net_ready), 64'(collecting && occ < 4));
      chk("out_valid", 64'(out_valid), 64'(occ != 0));
      chk("done",      64'(done),      64'(done_exp));
      chk("busy",      64'(busy),      64'(!done_exp));
      pp = (occ != 0) && out_ready;
      if (pp) begin
        chk("out_tag",  64'(out_tag),  64'(et[j]));
        chk("out_data", 64'(out_data), 64'(ev[j]));
        j++;
      end
      cap     = collecting && (occ < 4) && net_enable;
      done_nx = (k == n) && (occ == 0) && !done_exp;
      if (done_exp) done_seen = 1;
      k        = k + int'(cap);
      occ      = occ + int'(cap) - int'(pp);
      done_exp = done_nx;
      if (hold > 0 && cyc == hold - 1) chk("bp_captures", 64'(k), 64'((n < 4) ? n : 4));
      cyc++;
    end
    chk("run_finished", 64'(done_seen), 64'd1);
    chk("out_count",    64'(j),         64'(exp_n));
    net_enable = 1'b0; out_ready = 1'b0; net_value = '0;
  endtask

  task automatic do_prog();
    bit acc_exp;
    int n_set;
    n_set = 0;
    for (int i = 0; i <= 14; i++) begin
      @(negedge clk);
      prog_valid = (i <= 12);
      prog_id    = (i >= 1 && i <= 12) ? 4'(i - 1) : 4'($urandom);
      #1;
      acc_exp = (i >= 1 && i <= 12);
      chk("prog_ready", 64'(prog_ready), 64'(acc_exp));
      chk("set_id",     64'(set_id),     64'(acc_exp));
      chk("id_out",     64'(id_out),     acc_exp ? 64'(i - 1) : 64'd0);
      chk("prog_done",  64'(prog_done),  64'(i == 13));
      chk("prog_busy",  64'(busy),       64'(acc_exp));
      if (set_id) n_set++;
    end
    chk("prog_set_count", 64'(n_set), 64'd12);
  endtask

  initial begin
    rst = 1'b0; prog_valid = 1'b0; prog_id = '0; start = 1'b0;
    tag_first = '0; tag_last = '0; beats = '0;
    net_enable = 1'b0; net_value = '0; out_ready = 1'b0;

    vecs[0] = '{2, 4, 2, 100, 100, 0, 6};
    vecs[1] = '{14, 1, 1, 100, 100, 0, 4};
    vecs[2] = '{1, 1, 6, 100, 100, 12, 6};
    vecs[3] = '{5, 5, 0, 70, 60, 0, 1};
    vecs[4] = '{0, 15, 1, 60, 50, 0, 16};
    vecs[5] = '{7, 6, 1, 80, 70, 0, 16};
    vecs[6] = '{9, 10, 5, 50, 40, 0, 10};
    vecs[7] = '{12, 13, 3, 90, 30, 0, 6};

    repeat (3) @(negedge clk);
    #1;
    check_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    do_prog();

    for (int v = 0; v < 8; v++)
      run_collect(vecs[v].tf, vecs[v].tl, vecs[v].bt, vecs[v].en_pct,
                  vecs[v].rdy_pct, vecs[v].hold, vecs[v].exp_n);

    // Reset after the third capture, then a clean rerun from tag_first.
    @(negedge clk);
    start = 1'b1; tag_first = 4'd6; tag_last = 4'd9; beats = 8'd1; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      net_enable = 1'b1;
      net_value  = 32'h100 + 32'(i);
      #1;
      chk("rstseq_tag",       64'(tag),       64'(6 + i));
      chk("rstseq_net_ready", 64'(net_ready), 64'd1);
      @(negedge clk);
    end
    rst = 1'b0; net_enable = 1'b0; net_value = '0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    run_collect(6, 9, 1, 90, 80, 0, 4);

    // prog_valid has priority over start in IDLE.
    @(negedge clk);
    prog_valid = 1'b1; start = 1'b1;
    @(negedge clk);
    prog_valid = 1'b0; start = 1'b0;
    #1;
    chk("prio_prog_ready", 64'(prog_ready), 64'd1);
    chk("prio_net_ready",  64'(net_ready),  64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("prio_rst_busy", 64'(busy), 64'd0);

`ifdef GON_COLLECTOR_PERF_EN
    @(negedge clk);
    start = 1'b1; tag_first = 4'd3; tag_last = 4'd3; beats = 8'd1;
    @(negedge clk);
    start = 1'b0; net_enable = 1'b0;
    repeat (5) @(negedge clk);
    #1;
    chk("perf_idle_cnt",  64'(idle_cnt),  64'd5);
    chk("perf_stall_cnt", 64'(stall_cnt), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("perf_idle_rst", 64'(idle_cnt), 64'd0);
`endif

    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/gon_collector.md
GON_COLLECTOR -- requirements
Module: gon_collector

Interface
REQ-001 SHALL have parameter ID_LEN, default 4, width of PE id and tag.
REQ-002 SHALL have parameter VALUE_LEN, default 32, width of the value carried on the GON.
REQ-003 SHALL have parameter CHAIN_LEN, default 12, number of multicast controllers on the id scan chain.
REQ-004 SHALL have parameter FIFO_DEPTH, default 4, number of output FIFO entries; power of 2, at least 2.
REQ-005 Ports (name direction width meaning):
- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-low.
- prog_valid  in  1  id word offered for scan chain.
- prog_id  in  ID_LEN  id word.
- prog_ready  out  1  id word accepted.
- prog_done  out  1  one-cycle pulse after CHAIN_LEN ids accepted.
- set_id  out  1  scan-chain load strobe to controllers.
- id_out  out  ID_LEN  scan-chain head id.
- start  in  1  begin collection.
- tag_first  in  ID_LEN  first tag, sampled on start.
- tag_last  in  ID_LEN  last tag, sampled on start.
- beats_per_tag  in  8  values expected per tag, sampled on start.
- tag  out  ID_LEN  current tag broadcast to controllers.
- net_ready  out  1  collector can accept a value.
- net_enable  in  1  OR of controller enables; value valid.
- net_value  in  VALUE_LEN  OR of controller values.
- out_valid  out  1  FIFO head valid.
- out_ready  in  1  downstream accepts.
- out_data  out  VALUE_LEN  FIFO head value.
- out_tag  out  ID_LEN  tag captured with out_data.
- busy  out  1  state not IDLE.
- done  out  1  one-cycle pulse, collection complete.

Function
REQ-006 SHALL implement FSM IDLE, PROG, COLLECT, DRAIN; busy=1 outside IDLE.
REQ-007 IDLE: prog_valid=1 -> PROG; else start=1 -> COLLECT; prog_valid wins when both are asserted.
REQ-008 PROG: prog_ready=1; each accepted word drives set_id=1 and id_out=prog_id in the same cycle (combinational); otherwise set_id=0.
REQ-009 PROG: accept counter counts 0..CHAIN_LEN-1; on the CHAIN_LEN-th accept, prog_done=1 next cycle and the FSM returns to IDLE.
REQ-010 COLLECT: tag=cur_tag, initialised to tag_first at start; net_ready=1 iff FIFO count < FIFO_DEPTH.
REQ-011 Capture occurs when net_ready and net_enable are both 1; {cur_tag, net_value} is pushed to the FIFO in that same cycle.
REQ-012 beats_per_tag=0 SHALL be treated as 1.
REQ-013 On the last beat of a tag: if cur_tag==tag_last -> DRAIN; else cur_tag increments modulo 2^ID_LEN, so tag_last<tag_first wraps.
REQ-014 net_ready SHALL be 0 when the FIFO is full, even if a pop occurs that cycle (no pass-through).
REQ-015 net_enable while net_ready=0 SHALL be ignored; controllers hold their value.
REQ-016 DRAIN: net_ready=0; when the FIFO is empty, done=1 for one cycle and the FSM returns to IDLE.
REQ-017 start and prog_valid outside IDLE SHALL be ignored; prog_ready=0 outside PROG.
REQ-018 FIFO: pop on out_valid && out_ready; simultaneous push and pop leaves count unchanged; out_valid=(count!=0); first-word fall-through.
REQ-019 Outside COLLECT: tag=0 and net_ready=0.

Reset
REQ-020 rst=0 at a clock edge SHALL force IDLE, flush the FIFO, and clear all counters and cur_tag, including mid-PROG or mid-COLLECT.
REQ-021 Reset values: all outputs 0.

Configuration
REQ-022 With GON_COLLECTOR_PERF_EN defined: output stall_cnt (32) counts COLLECT cycles with net_ready=0, and output idle_cnt (32) counts COLLECT cycles with net_ready=1 and net_enable=0; both clear on start and on reset, and saturate at max.
REQ-023 Without GON_COLLECTOR_PERF_EN: both ports and both counters are absent; all other behaviour is identical.

Verification
REQ-024 Program: 12 prog words 0..11 with prog_valid held -> set_id high 12 cycles, id_out=0..11 in order, prog_done pulse in the cycle after the last word.
REQ-025 Collect: tag_first=2, tag_last=4, beats=2, out_ready=1, PE enables on matching tag -> out stream tags 2,2,3,3,4,4, then done.
REQ-026 Backpressure: out_ready=0, FIFO_DEPTH=4, enables held -> exactly 4 captures, net_ready=0; out_ready=1 resumes with no loss or duplication.
REQ-027 Wrap: tag_first=14, tag_last=1, beats=1 -> tags 14,15,0,1.
REQ-028 rst=0 after the 3rd capture -> all outputs 0 next cycle, out_valid=0; a new start runs cleanly from tag_first.
REQ-029 PERF_EN: 5 COLLECT cycles with no enable -> idle_cnt=5.
